// File: rtl/ns_txpkt_pkg.sv
// ns_txpkt_pkg
//   Shared definitions for the CMAC transmit packet sequencer and the tx
//   packet-size monitor: packet byte lengths, beat counts, type codes, the
//   sequencer state enum and the keep mask of the FC final beat.
package ns_txpkt_pkg;

  // Stream geometry: only a 512-bit (64-byte) beat is supported.
  localparam int TX_DW = 512;
  localparam int TX_KW = TX_DW / 8;

  // Packet lengths in bytes, header included.
  localparam int FD_BYTES = 4160;
  localparam int MD_BYTES = 192;
  localparam int FC_BYTES = 68;

  // Packet lengths in beats.
  localparam int FD_BEATS = 65;
  localparam int MD_BEATS = 3;
  localparam int FC_BEATS = 2;

  // Header type codes (byte 0 of beat 0).
  localparam logic [7:0] TYPE_FD = 8'd1;
  localparam logic [7:0] TYPE_MD = 8'd2;
  localparam logic [7:0] TYPE_FC = 8'd3;

  // FC ends with a 4-byte beat.
  localparam logic [TX_KW-1:0] FC_LAST_TKEEP = {{(TX_KW-4){1'b0}}, 4'hF};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FD   = 2'd1,
    ST_MD   = 2'd2,
    ST_FC   = 2'd3
  } state_t;

  // Type code carried in the header for a given packet state.
  function automatic logic [7:0] type_code(input state_t st);
    case (st)
      ST_FD:   return TYPE_FD;
      ST_MD:   return TYPE_MD;
      ST_FC:   return TYPE_FC;
      default: return 8'd0;
    endcase
  endfunction

  // Index of the final beat (the tlast beat) of a packet.
  function automatic logic [6:0] last_beat(input state_t st);
    case (st)
      ST_FD:   return 7'(FD_BEATS - 1);
      ST_MD:   return 7'(MD_BEATS - 1);
      ST_FC:   return 7'(FC_BEATS - 1);
      default: return 7'd0;
    endcase
  endfunction

endpackage

// File: rtl/ns_txpkt_beatgen.sv
// ns_txpkt_beatgen
//   Combinational beat formatter: given the packet state, frame number,
//   packet index within the frame and beat index within the packet, produces
//   the tdata/tkeep/tlast of that beat. The top registers the result.
// Ports:
//   state   in   packet type being formatted (ST_IDLE yields an all-zero beat)
//   frame   in   32-bit frame number f
//   pkt_idx in   packet index within the frame
//   beat    in   beat index within the packet (0 = header)
//   tdata   out  beat data
//   tkeep   out  byte enables
//   tlast   out  final beat of the packet
module ns_txpkt_beatgen
  import ns_txpkt_pkg::*;
(
  input  state_t             state,
  input  logic [31:0]        frame,
  input  logic [15:0]        pkt_idx,
  input  logic [6:0]         beat,
  output logic [TX_DW-1:0]   tdata,
  output logic [TX_KW-1:0]   tkeep,
  output logic               tlast
);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    tdata = '0;
    tkeep = '0;
    tlast = 1'b0;
    if (state != ST_IDLE) begin
      tkeep = '1;
      tlast = (beat == last_beat(state));
      if (beat == 7'd0) begin
        // Header: type, frame, packet index; every other byte zero.
        tdata[7:0]   = type_code(state);
        tdata[63:32] = frame;
        tdata[95:64] = {16'd0, pkt_idx};
      end else begin
        case (state)
          ST_FD: begin
            for (int l = 0; l < TX_DW / 32; l++) begin
              tdata[32*l +: 32] = {frame[15:0], 9'd0, beat};
            end
          end
          ST_MD: begin
            for (int l = 0; l < TX_DW / 32; l++) begin
              tdata[32*l +: 32] = frame;
            end
          end
          ST_FC: begin
            tdata[31:0] = frame + 32'd1;
            tkeep       = FC_LAST_TKEEP;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/ns_txpkt_sequencer.sv
// ns_txpkt_sequencer
//   Emits the CMAC transmit stream as, per frame, fd_per_frame FD packets, one
//   MD packet and one FC packet, for frame_count frames. All outputs are
//   registered; the next beat is formatted from the next position and loaded
//   on every handshake, so the stream has no bubbles at full tready.
// Ports:
//   clk, resetn      clock, synchronous active-low reset
//   start            pulse; accepted only when idle and frame_count != 0
//   frame_count      frames per run, sampled on accepted start
//   fd_per_frame     FD packets per frame, sampled on accepted start
//   busy             accepted start until the final beat handshakes
//   frames_sent      frames completed in the current/last run
//   axis_tx_*        AXI-Stream master toward the CMAC tx port
module ns_txpkt_sequencer
  import ns_txpkt_pkg::*;
#(
  parameter int DW = TX_DW
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [31:0]       frame_count,
  input  logic [15:0]       fd_per_frame,
  output logic              busy,
  output logic [31:0]       frames_sent,
  output logic [DW-1:0]     axis_tx_tdata,
  output logic [DW/8-1:0]   axis_tx_tkeep,
  output logic              axis_tx_tlast,
  output logic              axis_tx_tvalid,
  input  logic              axis_tx_tready
);

  // Position of the beat currently presented on the stream.
  state_t      state_q;
  logic [31:0] frame_q;
  logic [15:0] pkt_q;
  logic [6:0]  beat_q;

  // Run parameters captured on accepted start.
  logic [31:0] frames_total_q;
  logic [15:0] fd_n_q;

  // Next position and control.
  state_t      st_n;
  logic [31:0] fr_n;
  logic [15:0] pk_n;
  logic [6:0]  bt_n;
  logic        load;
  logic        start_ok;
  logic        sent_inc;

  logic [TX_DW-1:0] gen_data;
  logic [TX_KW-1:0] gen_keep;
  logic             gen_last;

  always_comb begin
    load     = 1'b0;
    start_ok = 1'b0;
    sent_inc = 1'b0;
    st_n     = state_q;
    fr_n     = frame_q;
    pk_n     = pkt_q;
    bt_n     = beat_q;
    if (state_q == ST_IDLE) begin
      if (start && (frame_count != 32'd0)) begin
        start_ok = 1'b1;
        load     = 1'b1;
        st_n     = (fd_per_frame != 16'd0) ? ST_FD : ST_MD;
        fr_n     = 32'd0;
        pk_n     = 16'd0;
        bt_n     = 7'd0;
      end
    end else if (axis_tx_tvalid && axis_tx_tready) begin
      load = 1'b1;
      if (!axis_tx_tlast) begin
        bt_n = beat_q + 7'd1;
      end else begin
        // End of packet: next packet starts at its header beat.
        bt_n = 7'd0;
        pk_n = pkt_q + 16'd1;
        case (state_q)
          ST_FD: if (pkt_q + 16'd1 == fd_n_q) st_n = ST_MD;
          ST_MD: st_n = ST_FC;
          ST_FC: begin
            sent_inc = 1'b1;
            pk_n     = 16'd0;
            fr_n     = frame_q + 32'd1;
            if (frame_q + 32'd1 == frames_total_q) st_n = ST_IDLE;
            else st_n = (fd_n_q != 16'd0) ? ST_FD : ST_MD;
          end
          default: ;
        endcase
      end
    end
  end

  ns_txpkt_beatgen u_beatgen (
    .state   (st_n),
    .frame   (fr_n),
    .pkt_idx (pk_n),
    .beat    (bt_n),
    .tdata   (gen_data),
    .tkeep   (gen_keep),
    .tlast   (gen_last)
  );

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (!resetn) begin
      state_q        <= ST_IDLE;
      frame_q        <= '0;
      pkt_q          <= '0;
      beat_q         <= '0;
      frames_total_q <= '0;
      fd_n_q         <= '0;
      busy           <= 1'b0;
      frames_sent    <= '0;
      axis_tx_tdata  <= '0;
      axis_tx_tkeep  <= '0;
      axis_tx_tlast  <= 1'b0;
      axis_tx_tvalid <= 1'b0;
    end else begin
      // Without a load the presented beat holds until it handshakes.
      if (load) begin
        state_q        <= st_n;
        frame_q        <= fr_n;
        pkt_q          <= pk_n;
        beat_q         <= bt_n;
        busy           <= (st_n != ST_IDLE);
        axis_tx_tvalid <= (st_n != ST_IDLE);
        axis_tx_tdata  <= gen_data;
        axis_tx_tkeep  <= gen_keep;
        axis_tx_tlast  <= gen_last;
      end
      if (start_ok) begin
        frames_total_q <= frame_count;
        fd_n_q         <= fd_per_frame;
        frames_sent    <= '0;
      end else if (sent_inc) begin
        frames_sent    <= frames_sent + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_ns_txpkt_sequencer.sv
// tb_ns_txpkt_sequencer
//   Directed bench for ns_txpkt_sequencer. Expected beats are built from the
//   packet format and pushed to a scoreboard when a run is started; a negedge
//   monitor compares every presented beat with the scoreboard head and
//   retires it on handshake.
module tb_ns_txpkt_sequencer;

  typedef struct packed {
    logic [511:0] d;
    logic [63:0]  k;
    logic         l;
  } beat_t;

  logic          clk;
  logic          resetn;
  logic          start;
  logic [31:0]   frame_count;
  logic [15:0]   fd_per_frame;
  logic          busy;
  logic [31:0]   frames_sent;
  logic [511:0]  tdata;
  logic [63:0]   tkeep;
  logic          tlast;
  logic          tvalid;
  logic          tready;

  int total = 0;
  int bad   = 0;

  beat_t exp_q[$];
  int    last_q[$];
  int    rd_idx   = 0;
  int    hs_count = 0;
  int    n_fd = 0, n_md = 0, n_fc = 0, n_other = 0;
  bit    sop = 1'b1;

  ns_txpkt_sequencer #(.DW(512)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .start          (start),
    .frame_count    (frame_count),
    .fd_per_frame   (fd_per_frame),
    .busy           (busy),
    .frames_sent    (frames_sent),
    .axis_tx_tdata  (tdata),
    .axis_tx_tkeep  (tkeep),
    .axis_tx_tlast  (tlast),
    .axis_tx_tvalid (tvalid),
    .axis_tx_tready (tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected model of one packet.
  task automatic push_pkt(input logic [7:0] ty, input logic [31:0] f,
                          input logic [31:0] idx, input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      beat_t x;
      logic [15:0] bk;
      bk  = 16'(b);
      x.d = '0;
      x.k = '1;
      x.l = (b == nbeats - 1);
      if (b == 0) begin
        x.d[7:0]   = ty;
        x.d[63:32] = f;
        x.d[95:64] = idx;
      end else if (ty == 8'd1) begin
        for (int l = 0; l < 16; l++) x.d[32*l +: 32] = {f[15:0], bk};
      end else if (ty == 8'd2) begin
        for (int l = 0; l < 16; l++) x.d[32*l +: 32] = f;
      end else begin
        x.d[31:0] = f + 32'd1;
        x.k       = 64'h000F;
      end
      exp_q.push_back(x);
    end
  endtask

  task automatic push_run(input int fc, input int fd);
    for (int f = 0; f < fc; f++) begin
      for (int p = 0; p < fd; p++) push_pkt(8'd1, 32'(f), 32'(p), 65);
      push_pkt(8'd2, 32'(f), 32'(fd), 3);
      push_pkt(8'd3, 32'(f), 32'(fd + 1), 2);
    end
  endtask

  // Starts a run and waits for it to end; bp selects 30 % tready duty,
  // mid_start pulses an extra start partway through.
  task automatic do_run(input int fc, input int fd, input bit bp, input bit mid_start);
    int base;
    bit done;
    base = hs_count;
    push_run(fc, fd);
    frame_count  = 32'(fc);
    fd_per_frame = 16'(fd);
    tready       = bp ? ($urandom_range(0, 9) < 3) : 1'b1;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_tvalid", tvalid, 1);
    check("start_frames_sent_clear", frames_sent, 0);
    done = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      if (mid_start && c == 100) begin
        start       = 1'b1;
        frame_count = 32'd7;
      end else if (mid_start && c == 101) begin
        start       = 1'b0;
        frame_count = 32'(fc);
      end
      tready = bp ? ($urandom_range(0, 9) < 3) : 1'b1;
      @(posedge clk); #1;
      if (!busy) begin
        done = 1'b1;
        break;
      end
      check("no_bubble", tvalid, 1);
    end
    tready = 1'b1;
    check("run_timeout", done, 1);
    check("end_tvalid", tvalid, 0);
    check("end_frames_sent", frames_sent, 32'(fc));
    check("beat_total", hs_count - base, fc * (65 * fd + 5));
    check("scoreboard_drained", rd_idx, exp_q.size());
  endtask

  // Monitor: sample half a cycle away from the active edge.
  always @(negedge clk) begin
    if (!resetn) begin
      rd_idx = exp_q.size();
      sop    = 1'b1;
    end else if (tvalid) begin
      if (rd_idx >= exp_q.size()) begin
        check("extra_beat", tvalid, 0);
      end else begin
        check("tdata", tdata, exp_q[rd_idx].d);
        check("tkeep", tkeep, exp_q[rd_idx].k);
        check("tlast", tlast, exp_q[rd_idx].l);
        if (tready) begin
          if (sop) begin
            case (tdata[7:0])
              8'd1:    n_fd++;
              8'd2:    n_md++;
              8'd3:    n_fc++;
              default: n_other++;
            endcase
          end
          sop = tlast;
          if (tlast) last_q.push_back(hs_count);
          hs_count++;
          rd_idx++;
        end
      end
    end
  end

  initial begin
    int b_fd, b_md, b_fc, b_oth, base, lbase;
    bit reached;
    resetn       = 1'b0;
    start        = 1'b0;
    frame_count  = '0;
    fd_per_frame = '0;
    tready       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_frames_sent", frames_sent, 0);
    check("rst_tvalid", tvalid, 0);
    check("rst_tlast", tlast, 0);
    check("rst_tdata", tdata, 0);
    check("rst_tkeep", tkeep, 0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Minimal run: MD then FC.
    do_run(1, 0, 1'b0, 1'b0);

    // Standard run with a start pulse mid-run that must be ignored.
    b_fd = n_fd; b_md = n_md; b_fc = n_fc; b_oth = n_other;
    do_run(3, 2, 1'b0, 1'b1);
    check("count_fd", n_fd - b_fd, 6);
    check("count_md", n_md - b_md, 3);
    check("count_fc", n_fc - b_fc, 3);
    check("count_other", n_other - b_oth, 0);

    // Same run under backpressure.
    do_run(3, 2, 1'b1, 1'b0);

    // start with frame_count = 0 is ignored; tready toggling has no effect.
    frame_count  = 32'd0;
    fd_per_frame = 16'd2;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tready = c[0];
      check("zero_start_busy", busy, 0);
      check("zero_start_tvalid", tvalid, 0);
      @(posedge clk); #1;
    end
    tready = 1'b1;

    // FD payload and tlast placement.
    lbase = last_q.size();
    base  = hs_count;
    do_run(1, 1, 1'b0, 1'b0);
    check("tlast_count", last_q.size() - lbase, 3);
    if (last_q.size() - lbase == 3) begin
      check("tlast_idx0", last_q[lbase] - base, 64);
      check("tlast_idx1", last_q[lbase + 1] - base, 67);
      check("tlast_idx2", last_q[lbase + 2] - base, 69);
    end

    // Reset while FD beat 30 is presented.
    base = hs_count;
    push_run(1, 1);
    frame_count  = 32'd1;
    fd_per_frame = 16'd1;
    start        = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    reached = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (hs_count - base == 30) begin
        reached = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("reach_fd_beat30", reached, 1);
    resetn = 1'b0;
    tready = 1'b0;
    @(posedge clk); #1;
    check("midrst_tvalid", tvalid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_frames_sent", frames_sent, 0);
    check("midrst_tlast", tlast, 0);
    resetn = 1'b1;
    tready = 1'b1;
    @(posedge clk); #1;
    do_run(1, 0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
